quad_snapshot_seq: RTL

//  Readout sequencer for the NCH quadrature counter channels. On a host snapshot request it

---
 rtl/quad_snapshot_seq_pkg.sv | 13 +
 rtl/quad_snapshot_seq_if.sv | 9 +
 rtl/quad_snapshot_seq_idx_sticky.sv | 22 ++
 rtl/quad_snapshot_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/quad_snapshot_seq_pkg.sv
// Shared types for the quadrature snapshot sequencer: FSM states and the hi-byte layout.
package quad_pkg;

   typedef enum logic [1:0] {StIdle, StStream, StDone} quad_state_e;

   localparam int unsigned QUAD_BYTES_PER_CH = 4;

   // value carries the upper counter bits already zero-extended to 7 bits
   function automatic logic [7:0] hi_byte(input logic flag, input logic [6:0] value);
      return {flag, value};
   endfunction

endpackage

// File: rtl/quad_snapshot_seq_if.sv
// Byte stream from the snapshot sequencer to the host-bus byte port (valid/ready).
interface quad_snapshot_seq_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/quad_snapshot_seq_idx_sticky.sv
// Per-channel sticky "index seen" flag; flag_o already includes a strobe on the current cycle.
module quad_idx_sticky (
   input  logic clk,
   input  logic rst,
   input  logic stb_i,
   input  logic clr_i,
   output logic flag_o
);

   logic flag_q, flag_d;

   // Clear wins over a coincident strobe; that strobe is still reported through flag_o.
   always_comb flag_d = clr_i ? 1'b0 : (flag_q | stb_i);

   always_ff @(posedge clk) begin
      if (rst) flag_q <= 1'b0;
      else     flag_q <= flag_d;
   end

   assign flag_o = flag_q | stb_i;

endmodule

// File: rtl/quad_snapshot_seq.sv
// Snapshot-and-stream readout of NCH quadrature channels over a byte valid/ready port.
// Define QUAD_SNAP_DELTA_EN to stream count deltas since the previous capture instead of absolutes.
module quad_snapshot_seq
   import quad_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned W   = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*W-1:0]     cnt_bus_i,
   input  logic [NCH*W-1:0]     idx_bus_i,
   input  logic [NCH-1:0]       idx_stb_i,
   input  logic                 snap_req_i,
   quad_snapshot_seq_if.master  out_io,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overrun_o
);

   localparam int unsigned NBytes = QUAD_BYTES_PER_CH * NCH;
   localparam int unsigned IdxW   = $clog2(NBytes);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

   quad_state_e      state_q;
   logic [W-1:0]     cnt_q [NCH];
   logic [W-1:0]     idx_q [NCH];
   logic [W-1:0]     cnt_cap [NCH];
   logic [NCH-1:0]   snap_flag_q;
   logic [NCH-1:0]   flag_live;
   logic [IdxW-1:0]  byte_idx_q;
   logic             valid_q, busy_q, done_q, overrun_q;
   logic [7:0]       bytes [NBytes];
   logic             capture;
   logic             accept;

   assign capture = snap_req_i && (state_q != StStream);
   assign accept  = valid_q && out_io.ready;

   for (genvar k = 0; k < NCH; k++) begin : g_sticky
      quad_idx_sticky u_sticky (
         .clk    (clk),
         .rst    (rst),
         .stb_i  (idx_stb_i[k]),
         .clr_i  (capture),
         .flag_o (flag_live[k])
      );
   end

`ifdef QUAD_SNAP_DELTA_EN
   logic [W-1:0] prev_q [NCH];

   always_comb begin
      for (int k = 0; k < NCH; k++) cnt_cap[k] = cnt_bus_i[k*W +: W] - prev_q[k];
   end
`else
   always_comb begin
      for (int k = 0; k < NCH; k++) cnt_cap[k] = cnt_bus_i[k*W +: W];
   end
`endif

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         bytes[4*k]     = cnt_q[k][7:0];
         bytes[4*k + 1] = hi_byte(snap_flag_q[k], 7'(cnt_q[k] >> 8));
         bytes[4*k + 2] = idx_q[k][7:0];
         bytes[4*k + 3] = hi_byte(1'b0, 7'(idx_q[k] >> 8));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         byte_idx_q  <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         snap_flag_q <= '0;
         for (int k = 0; k < NCH; k++) begin
            cnt_q[k] <= '0;
            idx_q[k] <= '0;
`ifdef QUAD_SNAP_DELTA_EN
            prev_q[k] <= '0;
`endif
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (capture) begin
                  state_q     <= StStream;
                  byte_idx_q  <= '0;
                  valid_q     <= 1'b1;
                  busy_q      <= 1'b1;
                  overrun_q   <= 1'b0;
                  snap_flag_q <= flag_live;
                  for (int k = 0; k < NCH; k++) begin
                     cnt_q[k] <= cnt_cap[k];
                     idx_q[k] <= idx_bus_i[k*W +: W];
`ifdef QUAD_SNAP_DELTA_EN
                     prev_q[k] <= cnt_bus_i[k*W +: W];
`endif
                  end
               end else begin
                  state_q <= StIdle;
               end
            end
            StStream: begin
               if (snap_req_i) overrun_q <= 1'b1;
               if (accept) begin
                  if (byte_idx_q == LastIdx) begin
                     state_q <= StDone;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     byte_idx_q <= byte_idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_io.data  = valid_q ? bytes[byte_idx_q] : 8'h00;
   assign out_io.valid = valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign overrun_o    = overrun_q;

endmodule
